// File: rtl/alu_nibble_sequencer_if.sv
// Nibble-wide bus between the sequencer and one combinational 4-bit ALU slice.
// The sequencer owns the operand/control side; the slice returns result, carries and compare.
interface alu_nibble_sequencer_if;
  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [2:0] slice_f;
  logic       slice_ci_right;
  logic       slice_ci_left;
  logic       slice_com;
  logic [3:0] slice_d;
  logic       slice_co_left;
  logic       slice_co_right;
  logic       slice_equ;

  modport master (
    output slice_a, slice_b, slice_f, slice_ci_right, slice_ci_left, slice_com,
    input  slice_d, slice_co_left, slice_co_right, slice_equ
  );

  modport slave (
    input  slice_a, slice_b, slice_f, slice_ci_right, slice_ci_left, slice_com,
    output slice_d, slice_co_left, slice_co_right, slice_equ
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Drives a 4-bit ALU slice one nibble per clock to build a 4*NIBBLES-bit operation,
// chaining carries between nibbles and assembling result, carry and status flags.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NIBBLES-1:0]    op_a,
  input  logic [4*NIBBLES-1:0]    op_b,
  input  logic [2:0]              func,
  input  logic                    com,
  input  logic                    cin,
  alu_nibble_sequencer_if.master  slice,
  output logic [4*NIBBLES-1:0]    result,
  output logic                    carry_out,
  output logic                    zero,
  output logic                    neg_zero,
  output logic                    equal,
  output logic                    busy,
  output logic                    done
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SHR = 3'd6;
  localparam logic [2:0] FN_SHL = 3'd7;

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nib_sel;
  logic [W-1:0]     a_q, b_q;
  logic [2:0]       func_q;
  logic             com_q;
  logic             carry_q;
  logic             carry_nxt;
  logic             eq_acc;
  logic [W-1:0]     result_q;
  logic             carry_out_q, equal_q, done_q;
  logic             is_shr, last_nib;

  assign is_shr   = (func_q == FN_SHR);
  assign nib_sel  = is_shr ? (IDX_W'(NIBBLES - 1) - idx) : idx;
  assign last_nib = (idx == IDX_W'(NIBBLES - 1));

  // Slice drive: everything held at zero while idle so the slice sees a quiet bus.
  always_comb begin
    slice.slice_a        = 4'd0;
    slice.slice_b        = 4'd0;
    slice.slice_f        = 3'd0;
    slice.slice_ci_right = 1'b0;
    slice.slice_ci_left  = 1'b0;
    slice.slice_com      = 1'b0;
    if (state == RUN) begin
      slice.slice_a   = a_q[{nib_sel, 2'b00} +: 4];
      slice.slice_b   = b_q[{nib_sel, 2'b00} +: 4];
      slice.slice_f   = func_q;
      slice.slice_com = com_q;
      case (func_q)
        FN_ADD, FN_SHL: slice.slice_ci_right = carry_q;
        FN_SHR:         slice.slice_ci_left  = carry_q;
        default: ;
      endcase
    end
  end

  // Carry that leaves this nibble towards the next one processed.
  always_comb begin
    carry_nxt = 1'b0;
    case (func_q)
      FN_ADD, FN_SHL: carry_nxt = slice.slice_co_left;
      FN_SHR:         carry_nxt = slice.slice_co_right;
      default:        carry_nxt = 1'b0;
    endcase
  end

  // Operand latches only load on accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q    <= op_a;
      b_q    <= op_b;
      func_q <= func;
      com_q  <= com;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry_q     <= 1'b0;
      eq_acc      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      equal_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            carry_q <= cin;
            eq_acc  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result_q[{nib_sel, 2'b00} +: 4] <= slice.slice_d;
          carry_q <= carry_nxt;
          eq_acc  <= eq_acc & slice.slice_equ;
          idx     <= idx + 1'b1;
          if (last_nib) begin
            carry_out_q <= carry_nxt;
            equal_q     <= eq_acc & slice.slice_equ;
            done_q      <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign equal     = equal_q;
  assign done      = done_q;
  assign busy      = (state == RUN);
  assign zero      = (result_q == '0);
  assign neg_zero  = (result_q == '1);
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 4-bit ALU slice attached.
module tb_alu_nibble_sequencer;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [2:0]   func = 3'd0;
  logic         com = 1'b0, cin = 1'b0;
  logic [W-1:0] result;
  logic         carry_out, zero, neg_zero, equal, busy, done;

  int passed = 0;
  int total  = 0;

  alu_nibble_sequencer_if sif();

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .func(func), .com(com), .cin(cin),
    .slice(sif),
    .result(result), .carry_out(carry_out), .zero(zero), .neg_zero(neg_zero),
    .equal(equal), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural slice: ADD/logic/pass/shift on one nibble, complement applied to d only.
  logic [4:0] s_sum;
  logic [3:0] s_raw;
  logic       s_col, s_cor;
  always_comb begin
    s_sum = {1'b0, sif.slice_a} + {1'b0, sif.slice_b} + {4'd0, sif.slice_ci_right};
    s_raw = 4'd0;
    s_col = 1'b0;
    s_cor = 1'b0;
    case (sif.slice_f)
      3'd0: begin s_raw = s_sum[3:0]; s_col = s_sum[4]; end
      3'd1: s_raw = sif.slice_a & sif.slice_b;
      3'd2: s_raw = sif.slice_a | sif.slice_b;
      3'd3: s_raw = sif.slice_a ^ sif.slice_b;
      3'd4: s_raw = sif.slice_a;
      3'd5: s_raw = sif.slice_b;
      3'd6: begin s_raw = {sif.slice_ci_left, sif.slice_a[3:1]}; s_cor = sif.slice_a[0]; end
      3'd7: begin s_raw = {sif.slice_a[2:0], sif.slice_ci_right}; s_col = sif.slice_a[3]; end
      default: ;
    endcase
    sif.slice_d        = sif.slice_com ? ~s_raw : s_raw;
    sif.slice_co_left  = s_col;
    sif.slice_co_right = s_cor;
    sif.slice_equ      = (sif.slice_a == sif.slice_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one operation, scramble operands after accept, wait (bounded) for done.
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic ci, output int lat);
    @(negedge clk);
    func = f; op_a = a; op_b = b; com = c; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = ~b; func = ~f; com = ~c; cin = ~ci;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, ndone, first_d, second_d, n;
  logic saw_done;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_negzero", neg_zero, 0);
    chk("rst_equal", equal, 0);
    chk("idle_slice_a", sif.slice_a, 0);
    rst_n = 1'b1;

    run_op(3'd0, 16'h1234, 16'hEDCC, 1'b0, 1'b0, lat);
    chk("add_latency", lat, 4);
    chk("add_result", result, 16'h0000);
    chk("add_carry", carry_out, 1);
    chk("add_zero", zero, 1);
    @(negedge clk);
    chk("add_done_pulse", done, 0);
    chk("add_busy_after", busy, 0);

    run_op(3'd7, 16'h8001, 16'h0000, 1'b0, 1'b1, lat);
    chk("shl_result", result, 16'h0003);
    chk("shl_carry", carry_out, 1);

    run_op(3'd6, 16'h8001, 16'h0000, 1'b0, 1'b0, lat);
    chk("shr_result", result, 16'h4000);
    chk("shr_carry", carry_out, 1);

    run_op(3'd3, 16'hFFFF, 16'h0F0F, 1'b1, 1'b0, lat);
    chk("xor_com_result", result, 16'h0F0F);
    chk("xor_com_carry", carry_out, 0);

    run_op(3'd4, 16'hFFFF, 16'h1234, 1'b0, 1'b0, lat);
    chk("passa_result", result, 16'hFFFF);
    chk("passa_negzero", neg_zero, 1);
    chk("passa_zero", zero, 0);

    run_op(3'd1, 16'hABCD, 16'hABCD, 1'b0, 1'b0, lat);
    chk("and_eq_result", result, 16'hABCD);
    chk("and_eq_equal", equal, 1);

    run_op(3'd1, 16'hABCD, 16'hABCC, 1'b0, 1'b0, lat);
    chk("and_ne_result", result, 16'hABCC);
    chk("and_ne_equal", equal, 0);

    // start pulsed while busy is dropped
    @(negedge clk);
    func = 3'd0; op_a = 16'h0001; op_b = 16'h0002; com = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op_a = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("busy_start_dones", ndone, 1);
    chk("busy_start_result", result, 16'h0003);

    // start held high: back-to-back accepts
    func = 3'd0; op_a = 16'h0001; op_b = 16'h0001; cin = 1'b0; com = 1'b0; start = 1'b1;
    ndone = 0; first_d = -1; second_d = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0) first_d = i;
        else if (ndone == 1) second_d = i;
        ndone++;
      end
    end
    start = 1'b0;
    chk("hold_ndone", ndone, 3);
    chk("hold_first", first_d, 4);
    chk("hold_second", second_d, 9);
    chk("hold_result", result, 16'h0002);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_drain", busy, 0);

    // reset in cycle 3 of an operation
    @(negedge clk);
    func = 3'd0; op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_zero", zero, 1);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (i == 1) rst_n = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);

    run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_result", result, 16'h0100);
    chk("post_rst_carry", carry_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
